ssd1306_spi_rx: RTL

SPI receiver and SSD1306 command decoder. It is the listening end of the display-init link: it deserialises mosi/spi_clk/en, assembles bytes and decodes the SSD1306 init command set into shadow configuration registers. It is used as an on-chip loopback checker and as a display model in system benches. It runs on its own clk and oversamples the SPI pins.

---
 rtl/ssd1306_spi_rx.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx: oversampling SPI receiver with an SSD1306 init-command decoder.
// The SPI pins are synchronised into clk, so clk must run at least 4x spi_clk.
// Bytes are assembled and then decoded into shadow configuration registers.
// Optional macro SSD1306_RX_CMD_COUNT_EN enables a saturating command counter
// on cmd_count. When the macro is undefined, cmd_count is tied to 0x00.
module ssd1306_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int LSB_FIRST   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_en,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       cmd_valid,
    output logic [7:0] cmd_opcode,
    output logic [7:0] cmd_arg,
    output logic       cmd_unknown,
    output logic       charge_pump_on,
    output logic [7:0] contrast,
    output logic [7:0] precharge,
    output logic       display_on,
    output logic       entire_on,
    output logic       frame_err,
    output logic [7:0] cmd_count
);

    typedef enum logic {IDLE, ARG} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] en_sync_reg;
    logic                   sclk_prev_reg;

    // Synchroniser chains are deliberately not reset. They keep tracking the
    // pins while rst_n is low. Because of this, a spi_clk that is already high
    // when reset is released is not seen as a fresh rising edge.
    always_ff @(posedge clk) begin
        sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
        en_sync_reg   <= {en_sync_reg[SYNC_STAGES-2:0], spi_en};
        sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
    end

    logic sclk_s;
    logic mosi_s;
    logic en_s;
    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign en_s   = en_sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Bit / byte assembly
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic [7:0] byte_data_reg;
    logic       byte_valid_reg;
    logic       bit_take;
    logic       byte_abort;

    assign bit_take   = sclk_s & ~sclk_prev_reg & en_s;
    assign byte_abort = ~en_s & (bit_cnt_reg != 3'd0);

    // Position the incoming bit according to the wire bit order.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shift_next = {mosi_s, shift_reg[7:1]};
        end else begin
            shift_next = {shift_reg[6:0], mosi_s};
        end
    end

    // Count bits, publish a byte on the 8th bit, and drop partial bytes when en falls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            byte_data_reg  <= 8'h00;
            byte_valid_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (bit_take) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) begin
                    byte_data_reg  <= shift_next;
                    byte_valid_reg <= 1'b1;
                end
            end else if (byte_abort) begin
                bit_cnt_reg <= 3'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decoder
    // ------------------------------------------------------------------
    state_t     state_reg, state_next;
    logic [7:0] op_latch_reg, op_latch_next;
    logic       cmd_valid_reg, cmd_valid_next;
    logic [7:0] cmd_opcode_reg, cmd_opcode_next;
    logic [7:0] cmd_arg_reg, cmd_arg_next;
    logic       cmd_unknown_reg, cmd_unknown_next;
    logic       charge_pump_reg, charge_pump_next;
    logic [7:0] contrast_reg, contrast_next;
    logic [7:0] precharge_reg, precharge_next;
    logic       display_on_reg, display_on_next;
    logic       entire_on_reg, entire_on_next;
    logic       frame_err_reg, frame_err_next;

    // Decoder state register and the shadow registers it drives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            op_latch_reg    <= 8'h00;
            cmd_valid_reg   <= 1'b0;
            cmd_opcode_reg  <= 8'h00;
            cmd_arg_reg     <= 8'h00;
            cmd_unknown_reg <= 1'b0;
            charge_pump_reg <= 1'b0;
            contrast_reg    <= 8'h7F;
            precharge_reg   <= 8'h22;
            display_on_reg  <= 1'b0;
            entire_on_reg   <= 1'b0;
            frame_err_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_latch_reg    <= op_latch_next;
            cmd_valid_reg   <= cmd_valid_next;
            cmd_opcode_reg  <= cmd_opcode_next;
            cmd_arg_reg     <= cmd_arg_next;
            cmd_unknown_reg <= cmd_unknown_next;
            charge_pump_reg <= charge_pump_next;
            contrast_reg    <= contrast_next;
            precharge_reg   <= precharge_next;
            display_on_reg  <= display_on_next;
            entire_on_reg   <= entire_on_next;
            frame_err_reg   <= frame_err_next;
        end
    end

    // Decode each received byte: a 1-byte command, an opcode that needs an argument, or an argument.
    always_comb begin
        state_next       = state_reg;
        op_latch_next    = op_latch_reg;
        cmd_valid_next   = 1'b0;
        cmd_opcode_next  = cmd_opcode_reg;
        cmd_arg_next     = cmd_arg_reg;
        cmd_unknown_next = cmd_unknown_reg;
        charge_pump_next = charge_pump_reg;
        contrast_next    = contrast_reg;
        precharge_next   = precharge_reg;
        display_on_next  = display_on_reg;
        entire_on_next   = entire_on_reg;
        frame_err_next   = byte_abort;
        case (state_reg)
            IDLE: begin
                if (byte_valid_reg) begin
                    case (byte_data_reg)
                        8'h8D, 8'h81, 8'hD9: begin
                            op_latch_next = byte_data_reg;
                            state_next    = ARG;
                        end
                        default: begin
                            cmd_valid_next   = 1'b1;
                            cmd_opcode_next  = byte_data_reg;
                            cmd_arg_next     = 8'h00;
                            cmd_unknown_next = 1'b0;
                            case (byte_data_reg)
                                8'hA4:   entire_on_next   = 1'b0;
                                8'hA5:   entire_on_next   = 1'b1;
                                8'hAE:   display_on_next  = 1'b0;
                                8'hAF:   display_on_next  = 1'b1;
                                default: cmd_unknown_next = 1'b1;
                            endcase
                        end
                    endcase
                end
            end
            ARG: begin
                if (byte_valid_reg) begin
                    cmd_valid_next   = 1'b1;
                    cmd_opcode_next  = op_latch_reg;
                    cmd_arg_next     = byte_data_reg;
                    cmd_unknown_next = 1'b0;
                    state_next       = IDLE;
                    case (op_latch_reg)
                        8'h8D:   charge_pump_next = byte_data_reg[2];
                        8'h81:   contrast_next    = byte_data_reg;
                        8'hD9:   precharge_next   = byte_data_reg;
                        default: ;
                    endcase
                end else if (!en_s) begin
                    // Frame ended before the argument arrived: abandon the command.
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SSD1306_RX_CMD_COUNT_EN
    logic [7:0] cmd_count_reg;

    // Saturating count of decoded commands. It updates on the same edge as cmd_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_count_reg <= 8'h00;
        end else if (cmd_valid_next && (cmd_count_reg != 8'hFF)) begin
            cmd_count_reg <= cmd_count_reg + 8'd1;
        end
    end

    assign cmd_count = cmd_count_reg;
`else
    assign cmd_count = 8'h00;
`endif

    assign byte_data      = byte_data_reg;
    assign byte_valid     = byte_valid_reg;
    assign cmd_valid      = cmd_valid_reg;
    assign cmd_opcode     = cmd_opcode_reg;
    assign cmd_arg        = cmd_arg_reg;
    assign cmd_unknown    = cmd_unknown_reg;
    assign charge_pump_on = charge_pump_reg;
    assign contrast       = contrast_reg;
    assign precharge      = precharge_reg;
    assign display_on     = display_on_reg;
    assign entire_on      = entire_on_reg;
    assign frame_err      = frame_err_reg;

endmodule
